// File: rtl/servo_adc_scheduler.sv
// Shares one current-sense ADC between four servo channels: on each PWM trigger,
// it converts every enabled channel in ascending order and registers the results.
module servo_adc_scheduler #(
    parameter int ADC_WIDTH = 12,
    parameter int TO_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 core_en,
    input  logic [3:0]           ch_en,
    input  logic                 measurement_trigger,
    input  logic                 clear_status,
    output logic                 adc_req,
    output logic [1:0]           adc_ch,
    input  logic                 adc_ack,
    input  logic [ADC_WIDTH-1:0] adc_data,
    output logic [ADC_WIDTH-1:0] i0,
    output logic [ADC_WIDTH-1:0] i1,
    output logic [ADC_WIDTH-1:0] i2,
    output logic [ADC_WIDTH-1:0] i3,
    output logic                 sample_valid,
    output logic                 busy,
    output logic                 overrun,
    output logic [3:0]           adc_timeout
);

    typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;

    // The counter starts at 0 on the first REQ cycle, so the request gives up
    // once the count would reach all-ones: 2**TO_WIDTH-1 request cycles in total.
    localparam logic [TO_WIDTH-1:0] CNT_LAST = {{(TO_WIDTH-1){1'b1}}, 1'b0};

    state_t                state_reg, state_next;
    logic [3:0]            mask_reg, mask_next;
    logic [1:0]            ch_reg, ch_next;
    logic [TO_WIDTH-1:0]   cnt_reg, cnt_next;
    logic                  sv_reg, sv_next;
    logic                  overrun_reg, overrun_next;
    logic [3:0]            timeout_reg, timeout_next;
    logic [ADC_WIDTH-1:0]  i_reg [4];
    logic                  wr_en;
    logic [3:0]            to_set;
    logic                  ovr_set;
    logic [3:0]            above_mask;

    genvar gi;

    function automatic logic [1:0] lowest_bit(input logic [3:0] m);
        lowest_bit = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (m[k]) lowest_bit = 2'(k);
        end
    endfunction

    // Channels of the latched mask that are still pending in this sweep.
    generate
        for (gi = 0; gi < 4; gi++) begin : g_above
            assign above_mask[gi] = mask_reg[gi] && (ch_reg < 2'(gi));
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        mask_next  = mask_reg;
        ch_next    = ch_reg;
        cnt_next   = cnt_reg;
        sv_next    = 1'b0;
        wr_en      = 1'b0;
        to_set     = 4'b0000;
        // The sample_valid cycle is already IDLE but still counts as busy for triggers.
        ovr_set    = measurement_trigger && ((state_reg != IDLE) || sv_reg);

        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (measurement_trigger && !sv_reg && core_en && (|ch_en)) begin
                    mask_next  = ch_en;
                    ch_next    = lowest_bit(ch_en);
                    state_next = REQ;
                end
            end
            REQ: begin
                cnt_next = cnt_reg + 1'b1;
                if (adc_ack) begin
                    wr_en = 1'b1;
                end else if (cnt_reg == CNT_LAST) begin
                    to_set = 4'b0001 << ch_reg;
                end
                if (adc_ack || (cnt_reg == CNT_LAST)) begin
                    cnt_next = '0;
                    if (|above_mask) begin
                        ch_next    = lowest_bit(above_mask);
                        state_next = GAP;
                    end else begin
                        sv_next    = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            GAP: begin
                state_next = REQ;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        overrun_next = (overrun_reg && !clear_status) || ovr_set;
        timeout_next = (timeout_reg & {4{!clear_status}}) | to_set;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg   <= IDLE;
            mask_reg    <= 4'b0000;
            ch_reg      <= 2'd0;
            cnt_reg     <= '0;
            sv_reg      <= 1'b0;
            overrun_reg <= 1'b0;
            timeout_reg <= 4'b0000;
        end else begin
            state_reg   <= state_next;
            mask_reg    <= mask_next;
            ch_reg      <= ch_next;
            cnt_reg     <= cnt_next;
            sv_reg      <= sv_next;
            overrun_reg <= overrun_next;
            timeout_reg <= timeout_next;
        end
    end

    generate
        for (gi = 0; gi < 4; gi++) begin : g_sample
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    i_reg[gi] <= '0;
                end else if (wr_en && (ch_reg == 2'(gi))) begin
                    i_reg[gi] <= adc_data;
                end
            end
        end
    endgenerate

    assign adc_req      = (state_reg == REQ);
    assign busy         = (state_reg != IDLE);
    assign adc_ch       = ch_reg;
    assign sample_valid = sv_reg;
    assign overrun      = overrun_reg;
    assign adc_timeout  = timeout_reg;
    assign i0           = i_reg[0];
    assign i1           = i_reg[1];
    assign i2           = i_reg[2];
    assign i3           = i_reg[3];

endmodule

// File: tb/tb_servo_adc_scheduler.sv
// Scoreboard bench for servo_adc_scheduler: expected conversions are queued when
// a trigger is driven and checked as the scheduler issues requests.
module tb_servo_adc_scheduler;

    logic        clk;
    logic        reset_n;
    logic        core_en;
    logic [3:0]  ch_en;
    logic        measurement_trigger;
    logic        clear_status;
    logic        adc_req;
    logic [1:0]  adc_ch;
    logic        adc_ack;
    logic [11:0] adc_data;
    logic [11:0] i0, i1, i2, i3;
    logic        sample_valid;
    logic        busy;
    logic        overrun;
    logic [3:0]  adc_timeout;

    typedef struct packed {
        logic [1:0]  ch;
        logic [11:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [11:0] model_i [4];
    int          checks;
    int          errors;

    servo_adc_scheduler #(.ADC_WIDTH(12), .TO_WIDTH(8)) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .core_en             (core_en),
        .ch_en               (ch_en),
        .measurement_trigger (measurement_trigger),
        .clear_status        (clear_status),
        .adc_req             (adc_req),
        .adc_ch              (adc_ch),
        .adc_ack             (adc_ack),
        .adc_data            (adc_data),
        .i0                  (i0),
        .i1                  (i1),
        .i2                  (i2),
        .i3                  (i3),
        .sample_valid        (sample_valid),
        .busy                (busy),
        .overrun             (overrun),
        .adc_timeout         (adc_timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Inputs are driven and outputs sampled 1 ns after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] i_val(input logic [1:0] c);
        case (c)
            2'd0:    return i0;
            2'd1:    return i1;
            2'd2:    return i2;
            default: return i3;
        endcase
    endfunction

    task automatic check_all_i(input string tag);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (i_val(2'(k)) !== model_i[k]) begin
                errors++;
                $display("FAIL %s i%0d: got %h expected %h", tag, k, i_val(2'(k)), model_i[k]);
            end
        end
    endtask

    task automatic start_sweep(input logic [3:0] mask, input logic [11:0] base);
        for (int k = 0; k < 4; k++) begin
            if (mask[k]) exp_q.push_back('{ch: 2'(k), data: base + 12'(k)});
        end
        ch_en = mask;
        measurement_trigger = 1'b1;
        tick();
        measurement_trigger = 1'b0;
    endtask

    // Serves every queued conversion; returns with the last ack just taken,
    // i.e. in the cycle sample_valid should be high.
    task automatic serve_sweep(input int ack_delay, input string tag);
        exp_t e;
        int   n;
        bit   first;
        first = 1'b1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n = 0;
            while (adc_req !== 1'b1 && n < 20) begin
                tick();
                n++;
            end
            checks++;
            if (adc_req !== 1'b1 || adc_ch !== e.ch || n != (first ? 0 : 1)) begin
                errors++;
                $display("FAIL %s req: req=%b ch=%0d wait=%0d expected req=1 ch=%0d wait=%0d",
                         tag, adc_req, adc_ch, n, e.ch, first ? 0 : 1);
            end
            repeat (ack_delay) tick();
            checks++;
            if (adc_req !== 1'b1 || adc_ch !== e.ch) begin
                errors++;
                $display("FAIL %s hold: req=%b ch=%0d expected req=1 ch=%0d", tag, adc_req, adc_ch, e.ch);
            end
            adc_ack  = 1'b1;
            adc_data = e.data;
            tick();
            adc_ack  = 1'b0;
            model_i[e.ch] = e.data;
            checks++;
            if (adc_req !== 1'b0 || i_val(e.ch) !== e.data || sample_valid !== (exp_q.size() == 0)) begin
                errors++;
                $display("FAIL %s ack ch%0d: req=%b i=%h sv=%b expected req=0 i=%h sv=%b",
                         tag, e.ch, adc_req, i_val(e.ch), sample_valid, e.data, exp_q.size() == 0);
            end
            first = 1'b0;
        end
    endtask

    task automatic test_reset();
        checks++;
        if (adc_req !== 1'b0 || adc_ch !== 2'd0 || busy !== 1'b0 || sample_valid !== 1'b0 ||
            overrun !== 1'b0 || adc_timeout !== 4'b0000) begin
            errors++;
            $display("FAIL reset ctrl: req=%b ch=%0d busy=%b sv=%b ovr=%b to=%b expected all 0",
                     adc_req, adc_ch, busy, sample_valid, overrun, adc_timeout);
        end
        check_all_i("reset");
    endtask

    task automatic test_full_sweep();
        start_sweep(4'hF, 12'h101);
        core_en = 1'b0;
        ch_en   = 4'h0;
        serve_sweep(3, "full");
        tick();
        checks++;
        if (sample_valid !== 1'b0 || busy !== 1'b0 || adc_req !== 1'b0) begin
            errors++;
            $display("FAIL full end: sv=%b busy=%b req=%b expected 0 0 0", sample_valid, busy, adc_req);
        end
        check_all_i("full");
        core_en = 1'b1;
    endtask

    task automatic test_sparse_mask();
        start_sweep(4'b1010, 12'h2A0);
        ch_en = 4'hF;
        serve_sweep(2, "sparse");
        tick();
        checks++;
        if (sample_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL sparse end: sv=%b busy=%b expected 0 0", sample_valid, busy);
        end
        check_all_i("sparse");
    endtask

    task automatic test_ignored();
        int hits;
        hits = 0;
        core_en = 1'b0;
        ch_en   = 4'hF;
        measurement_trigger = 1'b1;
        tick();
        measurement_trigger = 1'b0;
        core_en = 1'b1;
        ch_en   = 4'h0;
        repeat (3) begin
            if (adc_req !== 1'b0 || sample_valid !== 1'b0 || overrun !== 1'b0) hits++;
            tick();
        end
        measurement_trigger = 1'b1;
        tick();
        measurement_trigger = 1'b0;
        adc_ack  = 1'b1;
        adc_data = 12'hBAD;
        repeat (3) begin
            if (adc_req !== 1'b0 || sample_valid !== 1'b0 || overrun !== 1'b0) hits++;
            tick();
        end
        adc_ack = 1'b0;
        checks++;
        if (hits != 0) begin
            errors++;
            $display("FAIL ignored: %0d cycles with activity, expected 0", hits);
        end
        check_all_i("idle_ack");
    endtask

    task automatic test_timeout();
        int n;
        ch_en = 4'h1;
        measurement_trigger = 1'b1;
        tick();
        measurement_trigger = 1'b0;
        n = 0;
        while (adc_req === 1'b1 && n < 400) begin
            n++;
            tick();
        end
        checks++;
        if (n != 255 || adc_timeout !== 4'b0001 || sample_valid !== 1'b1) begin
            errors++;
            $display("FAIL timeout: req cycles=%0d to=%b sv=%b expected 255 0001 1", n, adc_timeout, sample_valid);
        end
        check_all_i("timeout");
        clear_status = 1'b1;
        tick();
        clear_status = 1'b0;
        checks++;
        if (adc_timeout !== 4'b0000) begin
            errors++;
            $display("FAIL timeout clear: to=%b expected 0000", adc_timeout);
        end
    endtask

    task automatic test_ack_at_terminal();
        ch_en = 4'h1;
        measurement_trigger = 1'b1;
        tick();
        measurement_trigger = 1'b0;
        repeat (254) tick();
        checks++;
        if (adc_req !== 1'b1) begin
            errors++;
            $display("FAIL terminal hold: req=%b expected 1 in 255th request cycle", adc_req);
        end
        adc_ack  = 1'b1;
        adc_data = 12'h5A5;
        tick();
        adc_ack  = 1'b0;
        model_i[0] = 12'h5A5;
        checks++;
        if (adc_timeout !== 4'b0000 || sample_valid !== 1'b1 || adc_req !== 1'b0) begin
            errors++;
            $display("FAIL terminal ack: to=%b sv=%b req=%b expected 0000 1 0", adc_timeout, sample_valid, adc_req);
        end
        check_all_i("terminal");
    endtask

    task automatic test_overrun();
        int hits;
        start_sweep(4'b0011, 12'h330);
        measurement_trigger = 1'b1;
        tick();
        measurement_trigger = 1'b0;
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun busy: ovr=%b expected 1", overrun);
        end
        serve_sweep(3, "overrun");
        hits = 0;
        repeat (6) begin
            tick();
            if (adc_req !== 1'b0 || busy !== 1'b0) hits++;
        end
        checks++;
        if (hits != 0) begin
            errors++;
            $display("FAIL overrun restart: %0d busy cycles after sweep, expected 0", hits);
        end
        check_all_i("overrun");
        clear_status = 1'b1;
        tick();
        clear_status = 1'b0;
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL overrun clear: ovr=%b expected 0", overrun);
        end
        start_sweep(4'b0100, 12'h440);
        serve_sweep(1, "sv_trig");
        measurement_trigger = 1'b1;
        tick();
        measurement_trigger = 1'b0;
        hits = 0;
        repeat (4) begin
            if (adc_req !== 1'b0) hits++;
            tick();
        end
        checks++;
        if (overrun !== 1'b1 || hits != 0) begin
            errors++;
            $display("FAIL overrun sv cycle: ovr=%b req cycles=%0d expected 1 0", overrun, hits);
        end
    endtask

    task automatic test_reset_mid_sweep();
        ch_en = 4'hF;
        measurement_trigger = 1'b1;
        tick();
        measurement_trigger = 1'b0;
        checks++;
        if (adc_req !== 1'b1) begin
            errors++;
            $display("FAIL mid reset pre: req=%b expected 1", adc_req);
        end
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++) model_i[k] = 12'h000;
        checks++;
        if (adc_req !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0 || adc_timeout !== 4'b0000 ||
            sample_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid reset: req=%b busy=%b ovr=%b to=%b sv=%b expected all 0",
                     adc_req, busy, overrun, adc_timeout, sample_valid);
        end
        check_all_i("mid_reset");
        adc_ack  = 1'b1;
        adc_data = 12'hABC;
        tick();
        adc_ack  = 1'b0;
        checks++;
        if (adc_req !== 1'b0 || sample_valid !== 1'b0) begin
            errors++;
            $display("FAIL late ack: req=%b sv=%b expected 0 0", adc_req, sample_valid);
        end
        check_all_i("late_ack");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int k = 0; k < 4; k++) model_i[k] = 12'h000;
        reset_n             = 1'b0;
        core_en             = 1'b1;
        ch_en               = 4'h0;
        measurement_trigger = 1'b0;
        clear_status        = 1'b0;
        adc_ack             = 1'b0;
        adc_data            = 12'h000;
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        test_reset();
        test_full_sweep();
        test_sparse_mask();
        test_ignored();
        test_timeout();
        test_ack_at_terminal();
        test_overrun();
        test_reset_mid_sweep();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
